exception_entry_ctrl: RTL and testbench

- Exception-entry sequencer placed directly upstream of the banked register file.
- At an instruction boundary it prioritises pending FIQ, IRQ, UND and SWI requests.
- It then drives the register file's Change_M, write port and PC port to bank-write LR, save SPSR, update CPSR and jump to the vector.
- The pipeline stalls on Exc_Busy while the sequence runs.

---
 rtl/exception_entry_ctrl_if.sv | 36 +++
 rtl/exception_entry_ctrl.sv | 150 +++++++++++++++
 tb/tb_exception_entry_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/exception_entry_ctrl_if.sv
// Exception-entry bundle: requests and core state in, register-file controls out.
interface exception_entry_ctrl_if;
    logic        irq;
    logic        fiq;
    logic        und_req;
    logic        swi_req;
    logic        instr_done;
    logic [31:0] PC_Cur;
    logic [31:0] CPSR_In;
    logic        Exc_Busy;
    logic [2:0]  Change_M;
    logic        Write_Reg;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_PC;
    logic [31:0] PC_New;
    logic        Write_SPSR;
    logic [31:0] SPSR_New;
    logic        Write_CPSR;
    logic [31:0] CPSR_New;
    logic [1:0]  Exc_Cause;

    // Core / request side
    modport master (
        output irq, fiq, und_req, swi_req, instr_done, PC_Cur, CPSR_In,
        input  Exc_Busy, Change_M, Write_Reg, W_Addr, W_Data, Write_PC, PC_New,
               Write_SPSR, SPSR_New, Write_CPSR, CPSR_New, Exc_Cause
    );

    // Sequencer side
    modport slave (
        input  irq, fiq, und_req, swi_req, instr_done, PC_Cur, CPSR_In,
        output Exc_Busy, Change_M, Write_Reg, W_Addr, W_Data, Write_PC, PC_New,
               Write_SPSR, SPSR_New, Write_CPSR, CPSR_New, Exc_Cause
    );
endinterface

// File: rtl/exception_entry_ctrl.sv
// Exception-entry sequencer: at an instruction boundary picks the highest
// pending exception, then drives LR, SPSR, CPSR and PC writes into the
// banked register file over four stalled cycles.
module exception_entry_ctrl #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    rst,
    exception_entry_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_LR,
        SAVE_SPSR,
        SET_CPSR,
        JUMP
    } state_t;

    state_t      state;

    // Captured on the accepting edge
    logic [31:0] saved_cpsr;
    logic [4:0]  tgt_mode;
    logic [2:0]  tgt_code;
    logic [4:0]  vec_off;
    logic        was_fiq;

    // Decoded request for the current boundary
    logic        fiq_q;
    logic        irq_q;
    logic        acc_d;
    logic [1:0]  cause_d;
    logic [4:0]  mode_d;
    logic [2:0]  code_d;
    logic [31:0] ret_d;
    logic [4:0]  off_d;

    // Priority select among masked interrupts and synchronous requests
    always_comb begin
        fiq_q   = bus.fiq & ~bus.CPSR_In[6];
        irq_q   = bus.irq & ~bus.CPSR_In[7];
        acc_d   = 1'b0;
        cause_d = '0;
        mode_d  = '0;
        code_d  = '0;
        ret_d   = '0;
        off_d   = '0;
        if (bus.instr_done) begin
            if (fiq_q) begin
                acc_d = 1'b1; cause_d = 2'd3; mode_d = 5'b10001; code_d = 3'd1;
                ret_d = bus.PC_Cur + 32'd4; off_d = 5'h1C;
            end else if (irq_q) begin
                acc_d = 1'b1; cause_d = 2'd2; mode_d = 5'b10010; code_d = 3'd2;
                ret_d = bus.PC_Cur + 32'd4; off_d = 5'h18;
            end else if (bus.und_req) begin
                acc_d = 1'b1; cause_d = 2'd0; mode_d = 5'b11011; code_d = 3'd4;
                ret_d = bus.PC_Cur; off_d = 5'h04;
            end else if (bus.swi_req) begin
                acc_d = 1'b1; cause_d = 2'd1; mode_d = 5'b10011; code_d = 3'd3;
                ret_d = bus.PC_Cur; off_d = 5'h08;
            end
        end
    end

    // Sequencer with registered Moore outputs: each transition loads the
    // outputs belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            saved_cpsr     <= '0;
            tgt_mode       <= '0;
            tgt_code       <= '0;
            vec_off        <= '0;
            was_fiq        <= 1'b0;
            bus.Exc_Busy   <= 1'b0;
            bus.Change_M   <= '0;
            bus.Write_Reg  <= 1'b0;
            bus.W_Addr     <= '0;
            bus.W_Data     <= '0;
            bus.Write_PC   <= 1'b0;
            bus.PC_New     <= '0;
            bus.Write_SPSR <= 1'b0;
            bus.SPSR_New   <= '0;
            bus.Write_CPSR <= 1'b0;
            bus.CPSR_New   <= '0;
            bus.Exc_Cause  <= '0;
        end else begin
            bus.Change_M   <= '0;
            bus.Write_Reg  <= 1'b0;
            bus.W_Addr     <= '0;
            bus.W_Data     <= '0;
            bus.Write_PC   <= 1'b0;
            bus.PC_New     <= '0;
            bus.Write_SPSR <= 1'b0;
            bus.SPSR_New   <= '0;
            bus.Write_CPSR <= 1'b0;
            bus.CPSR_New   <= '0;
            case (state)
                IDLE: begin
                    bus.Exc_Busy <= 1'b0;
                    if (acc_d) begin
                        state         <= SAVE_LR;
                        saved_cpsr    <= bus.CPSR_In;
                        tgt_mode      <= mode_d;
                        tgt_code      <= code_d;
                        vec_off       <= off_d;
                        was_fiq       <= (cause_d == 2'd3);
                        bus.Exc_Cause <= cause_d;
                        bus.Exc_Busy  <= 1'b1;
                        bus.Write_Reg <= 1'b1;
                        bus.W_Addr    <= 4'd14;
                        bus.W_Data    <= ret_d;
                        bus.Change_M  <= code_d;
                    end
                end
                SAVE_LR: begin
                    state          <= SAVE_SPSR;
                    bus.Exc_Busy   <= 1'b1;
                    bus.Write_SPSR <= 1'b1;
                    bus.SPSR_New   <= saved_cpsr;
                    bus.Change_M   <= tgt_code;
                end
                SAVE_SPSR: begin
                    state          <= SET_CPSR;
                    bus.Exc_Busy   <= 1'b1;
                    bus.Write_CPSR <= 1'b1;
                    bus.CPSR_New   <= {saved_cpsr[31:8], 1'b1,
                                       (was_fiq | saved_cpsr[6]), 1'b0, tgt_mode};
                    bus.Change_M   <= tgt_code;
                end
                SET_CPSR: begin
                    state        <= JUMP;
                    bus.Exc_Busy <= 1'b1;
                    bus.Write_PC <= 1'b1;
                    bus.PC_New   <= VECTOR_BASE + {27'd0, vec_off};
                end
                JUMP: begin
                    state        <= IDLE;
                    bus.Exc_Busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.Exc_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_entry_ctrl.sv
// Scoreboard bench for exception_entry_ctrl: each accepted boundary pushes
// four expected output cycles; the negedge monitor pops and compares them.
module tb_exception_entry_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exception_entry_ctrl_if b1 ();
    exception_entry_ctrl_if b2 ();

    exception_entry_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    exception_entry_ctrl #(.VECTOR_BASE(32'hFFFF_0000)) dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    typedef struct {
        logic [2:0]  cm;
        logic [3:0]  strb;   // {Write_Reg, Write_SPSR, Write_CPSR, Write_PC}
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [31:0] spsr;
        logic [31:0] cpsr;
        logic [31:0] pcn;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [1:0] last_cause = 2'd0;
    logic       mon_en = 1'b0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference: builds the four expected cycles of an entry, if any
    task automatic push_expected(input logic i, f, u, s, input logic [31:0] pc, cpsr);
        logic fq, iq;
        logic [1:0]  cause;
        logic [4:0]  mode;
        logic [2:0]  code;
        logic [31:0] ret, off, newc;
        exp_t x;
        fq = f & ~cpsr[6];
        iq = i & ~cpsr[7];
        if (fq)     begin cause = 3; mode = 5'h11; code = 1; ret = pc + 4; off = 32'h1C; end
        else if (iq) begin cause = 2; mode = 5'h12; code = 2; ret = pc + 4; off = 32'h18; end
        else if (u) begin cause = 0; mode = 5'h1B; code = 4; ret = pc;     off = 32'h04; end
        else if (s) begin cause = 1; mode = 5'h13; code = 3; ret = pc;     off = 32'h08; end
        else return;
        newc = cpsr;
        newc[7] = 1'b1;
        if (fq) newc[6] = 1'b1;
        newc[5] = 1'b0;
        newc[4:0] = mode;
        x = '{cm: code, strb: 4'b1000, wa: 4'd14, wd: ret, spsr: 0, cpsr: 0, pcn: 0, cause: cause};
        sb.push_back(x);
        x = '{cm: code, strb: 4'b0100, wa: 0, wd: 0, spsr: cpsr, cpsr: 0, pcn: 0, cause: cause};
        sb.push_back(x);
        x = '{cm: code, strb: 4'b0010, wa: 0, wd: 0, spsr: 0, cpsr: newc, pcn: 0, cause: cause};
        sb.push_back(x);
        x = '{cm: 0, strb: 4'b0001, wa: 0, wd: 0, spsr: 0, cpsr: 0, pcn: off, cause: cause};
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One instruction boundary on the main DUT
    task automatic boundary(input logic i, f, u, s, input logic [31:0] pc, cpsr);
        b1.irq = i; b1.fiq = f; b1.und_req = u; b1.swi_req = s;
        b1.PC_Cur = pc; b1.CPSR_In = cpsr; b1.instr_done = 1'b1;
        @(posedge clk); #1;
        push_expected(i, f, u, s, pc, cpsr);
        b1.irq = 0; b1.fiq = 0; b1.und_req = 0; b1.swi_req = 0; b1.instr_done = 0;
    endtask

    // Monitor: pop an expected cycle when one is due, otherwise require quiet outputs
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("busy",     160'(b1.Exc_Busy), 160'(1'b1));
                check("change_m", 160'(b1.Change_M), 160'(e.cm));
                check("strobes",  160'({b1.Write_Reg, b1.Write_SPSR, b1.Write_CPSR, b1.Write_PC}), 160'(e.strb));
                check("w_addr",   160'(b1.W_Addr),   160'(e.wa));
                check("w_data",   160'(b1.W_Data),   160'(e.wd));
                check("spsr_new", 160'(b1.SPSR_New), 160'(e.spsr));
                check("cpsr_new", 160'(b1.CPSR_New), 160'(e.cpsr));
                check("pc_new",   160'(b1.PC_New),   160'(e.pcn));
                check("cause",    160'(b1.Exc_Cause), 160'(e.cause));
                last_cause = e.cause;
            end else begin
                check("idle_busy",    160'(b1.Exc_Busy), 160'(1'b0));
                check("idle_strobes", 160'({b1.Write_Reg, b1.Write_SPSR, b1.Write_CPSR, b1.Write_PC}), 160'(4'b0));
                check("idle_data",    160'({b1.Change_M, b1.W_Addr, b1.W_Data, b1.SPSR_New, b1.CPSR_New, b1.PC_New}), 160'(0));
                check("idle_cause",   160'(b1.Exc_Cause), 160'(last_cause));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.irq = 0; b1.fiq = 0; b1.und_req = 0; b1.swi_req = 0; b1.instr_done = 0;
        b1.PC_Cur = 0; b1.CPSR_In = 0;
        b2.irq = 0; b2.fiq = 0; b2.und_req = 0; b2.swi_req = 0; b2.instr_done = 0;
        b2.PC_Cur = 0; b2.CPSR_In = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // IRQ entry from user mode
        boundary(1, 0, 0, 0, 32'h100, 32'h10); idle(6);
        // IRQ masked by I
        boundary(1, 0, 0, 0, 32'h100, 32'h90); idle(3);
        // FIQ beats IRQ
        boundary(1, 1, 0, 0, 32'h300, 32'h10); idle(6);
        // FIQ masked by F, IRQ taken
        boundary(1, 1, 0, 0, 32'h340, 32'h50); idle(6);
        // UND beats SWI
        boundary(0, 0, 1, 1, 32'h200, 32'h10); idle(6);
        // SWI alone
        boundary(0, 0, 0, 1, 32'h400, 32'h1F); idle(6);

        // Requests while busy are ignored
        boundary(1, 0, 0, 0, 32'h500, 32'h10);
        b1.irq = 1; b1.und_req = 1; b1.instr_done = 1; b1.PC_Cur = 32'hDEAD;
        idle(2);
        b1.irq = 0; b1.und_req = 0; b1.instr_done = 0;
        idle(5);
        // Boundary with no request
        boundary(0, 0, 0, 0, 32'h600, 32'h10); idle(3);

        // Reset while in SAVE_SPSR aborts the sequence
        boundary(1, 0, 0, 0, 32'h700, 32'h10);
        idle(1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        last_cause = 2'd0;
        idle(1);
        rst = 1'b0;
        idle(6);

        // Return-address wrap and vector base override on the second instance
        b2.irq = 1; b2.PC_Cur = 32'hFFFF_FFFC; b2.CPSR_In = 32'h10; b2.instr_done = 1;
        @(posedge clk); #1;
        b2.irq = 0; b2.instr_done = 0;
        @(negedge clk);
        check("hi_write_reg", 160'(b2.Write_Reg), 160'(1'b1));
        check("hi_lr_wrap",   160'(b2.W_Data),    160'(32'h0000_0000));
        repeat (3) @(negedge clk);
        check("hi_write_pc",  160'(b2.Write_PC),  160'(1'b1));
        check("hi_pc_new",    160'(b2.PC_New),    160'(32'hFFFF_0018));
        check("hi_change_m",  160'(b2.Change_M),  160'(3'd0));
        @(posedge clk); #1;
        idle(3);

        // Random boundaries
        for (int k = 0; k < 24; k++) begin
            boundary(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom, {$urandom_range(0, 3) == 0 ? 24'h00_0000 : 24'hF0_0000, 8'($urandom)});
            idle(5 + int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
